// File: rtl/tile_scan_addr_gen_if.sv
// Beat bus between the tiled scan generator and the feature-map read port.
// The generator owns every field except ready, which the consumer drives.
interface tile_scan_addr_gen_if #(
  parameter int AW    = 7,
  parameter int REP_W = 7,
  parameter int CH_W  = 4,
  parameter int TW    = 10
);
  logic             valid;
  logic             ready;
  logic [AW-1:0]    row;
  logic [AW-1:0]    col;
  logic [CH_W-1:0]  chan;
  logic [REP_W-1:0] rep_idx;
  logic [TW-1:0]    tile_idx;
  logic             tile_first;
  logic             last;

  modport master (
    output valid, row, col, chan, rep_idx, tile_idx, tile_first, last,
    input  ready
  );

  modport slave (
    input  valid, row, col, chan, rep_idx, tile_idx, tile_first, last,
    output ready
  );
endinterface

// File: rtl/tile_scan_addr_gen.sv
// Tiled feature-map address generator: tile raster, pixel raster inside a tile,
// then channel, each (row,col,chan) held for rep beats, with valid/ready stalls.
//
// state  | meaning
// S_IDLE | waiting for start, all outputs 0
// S_RUN  | emitting beats, out_valid high, counters advance on accept
// S_DONE | one-cycle done pulse; start here launches the next scan
module tile_scan_addr_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int TILE  = 8,
  parameter int AW    = 7,
  parameter int REP_W = 7,
  parameter int CH_W  = 4,
  parameter int TW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [REP_W-1:0] i_cfg_rep,
  input  logic [CH_W-1:0]  i_cfg_chans,
  output logic             o_busy,
  output logic             o_done,
  tile_scan_addr_gen_if.master o_scan
);

  localparam int TB_W = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int TX_N = IMG_W / TILE;
  localparam int TY_N = IMG_H / TILE;
  localparam int TXW  = (TX_N > 1) ? $clog2(TX_N) : 1;
  localparam int TYW  = (TY_N > 1) ? $clog2(TY_N) : 1;
  localparam logic [TB_W-1:0] PIX_LAST = TB_W'(TILE - 1);
  localparam logic [TXW-1:0]  TX_LAST  = TXW'(TX_N - 1);
  localparam logic [TYW-1:0]  TY_LAST  = TYW'(TY_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [REP_W-1:0] r_rep_last;
  logic [CH_W-1:0]  r_chan_last;
  logic [REP_W-1:0] r_rep;
  logic [CH_W-1:0]  r_chan;
  logic [TB_W-1:0]  r_in_x;
  logic [TB_W-1:0]  r_in_y;
  logic [TXW-1:0]   r_tile_x;
  logic [TYW-1:0]   r_tile_y;
  logic [TW-1:0]    r_tile_idx;

  logic w_run, w_accept, w_last;
  logic w_rep_tc, w_chan_tc, w_x_tc, w_y_tc, w_tx_tc, w_ty_tc;

  assign w_run     = (r_state == S_RUN);
  assign w_accept  = w_run && o_scan.ready;
  assign w_rep_tc  = (r_rep == r_rep_last);
  assign w_chan_tc = (r_chan == r_chan_last);
  assign w_x_tc    = (r_in_x == PIX_LAST);
  assign w_y_tc    = (r_in_y == PIX_LAST);
  assign w_tx_tc   = (r_tile_x == TX_LAST);
  assign w_ty_tc   = (r_tile_y == TY_LAST);
  assign w_last    = w_run && w_rep_tc && w_chan_tc && w_x_tc && w_y_tc && w_tx_tc && w_ty_tc;

  // TILE is a power of two, so tile*TILE + offset is a plain concatenation.
  assign o_scan.row        = AW'({r_tile_y, r_in_y});
  assign o_scan.col        = AW'({r_tile_x, r_in_x});
  assign o_scan.chan       = r_chan;
  assign o_scan.rep_idx    = r_rep;
  assign o_scan.tile_idx   = r_tile_idx;
  assign o_scan.valid      = w_run;
  assign o_scan.last       = w_last;
  assign o_scan.tile_first = w_run && (r_rep == '0) && (r_chan == '0) &&
                             (r_in_x == '0) && (r_in_y == '0);
  assign o_busy            = w_run;
  assign o_done            = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rep_last  <= '0;
      r_chan_last <= '0;
      r_rep       <= '0;
      r_chan      <= '0;
      r_in_x      <= '0;
      r_in_y      <= '0;
      r_tile_x    <= '0;
      r_tile_y    <= '0;
      r_tile_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (i_start) begin
            // Zero counts behave as one beat / one channel.
            r_rep_last  <= (i_cfg_rep == '0)   ? '0 : i_cfg_rep - REP_W'(1);
            r_chan_last <= (i_cfg_chans == '0) ? '0 : i_cfg_chans - CH_W'(1);
            r_rep       <= '0;
            r_chan      <= '0;
            r_in_x      <= '0;
            r_in_y      <= '0;
            r_tile_x    <= '0;
            r_tile_y    <= '0;
            r_tile_idx  <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_rep <= w_rep_tc ? '0 : r_rep + REP_W'(1);
            if (w_rep_tc) r_chan <= w_chan_tc ? '0 : r_chan + CH_W'(1);
            if (w_rep_tc && w_chan_tc) begin
              r_in_x <= w_x_tc ? '0 : r_in_x + TB_W'(1);
              if (w_x_tc) begin
                r_in_y <= w_y_tc ? '0 : r_in_y + TB_W'(1);
                if (w_y_tc) begin
                  r_tile_x   <= w_tx_tc ? '0 : r_tile_x + TXW'(1);
                  r_tile_idx <= (w_tx_tc && w_ty_tc) ? '0 : r_tile_idx + TW'(1);
                  if (w_tx_tc) r_tile_y <= w_ty_tc ? '0 : r_tile_y + TYW'(1);
                end
              end
            end
            if (w_last) r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
